// File: rtl/frame_loader.sv
// Byte-stream RGB565 frame writer for the dual-bank buffer read by led_output.
// Define FRAME_LOADER_CHECKSUM_EN to require a trailing modulo-256 frame checksum.
module frame_loader #(
    parameter int MATRIX_HEIGHT = 32,
    parameter int MATRIX_WIDTH  = 64,
    localparam int BANK_SIZE    = (MATRIX_HEIGHT * MATRIX_WIDTH) / 2,
    localparam int AW           = $clog2(BANK_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sof,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          bank0_wen,
    output logic          bank1_wen,
    output logic [AW-1:0] w_addr,
    output logic [15:0]   w_data,
    output logic          go,
    output logic          busy,
    output logic          frame_err
);

    localparam int HALF = MATRIX_HEIGHT / 2;
    localparam int XW   = $clog2(MATRIX_WIDTH);
    localparam int YW   = $clog2(MATRIX_HEIGHT);

    localparam logic [XW-1:0] X_LAST = XW'(MATRIX_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MATRIX_HEIGHT - 1);
    localparam logic [YW-1:0] Y_HALF = YW'(HALF);

`ifdef FRAME_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HI, LO, DONE, CHK
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, HI, LO, DONE
    } state_t;
`endif

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    hi_byte;
    logic          accept;
    logic          top;
    logic          last_px;
    logic [YW-1:0] y_row;
    logic [AW-1:0] addr_c;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state != DONE);
    assign busy     = (state != IDLE);

    assign top     = (y < Y_HALF);
    assign y_row   = top ? y : y - Y_HALF;
    assign addr_c  = AW'(y_row) * AW'(MATRIX_WIDTH) + AW'(x);
    assign last_px = (x == X_LAST) && (y == Y_LAST);

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            hi_byte   <= '0;
            bank0_wen <= 1'b0;
            bank1_wen <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            go        <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            sum       <= '0;
            frame_err <= 1'b0;
`endif
        end else begin
            bank0_wen <= 1'b0;
            bank1_wen <= 1'b0;
            go        <= 1'b0;
            // An accepted sof byte always restarts as the high byte of pixel 0
            if (accept && sof) begin
                hi_byte <= in_data;
                x       <= '0;
                y       <= '0;
                state   <= LO;
`ifdef FRAME_LOADER_CHECKSUM_EN
                sum       <= in_data;
                frame_err <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: ;
                    HI: begin
                        if (accept) begin
                            hi_byte <= in_data;
                            state   <= LO;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            sum <= sum + in_data;
`endif
                        end
                    end
                    LO: begin
                        if (accept) begin
                            w_data    <= {hi_byte, in_data};
                            w_addr    <= addr_c;
                            bank0_wen <= top;
                            bank1_wen <= !top;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            sum <= sum + in_data;
`endif
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
`ifdef FRAME_LOADER_CHECKSUM_EN
                            state <= last_px ? CHK : HI;
`else
                            state <= last_px ? DONE : HI;
`endif
                        end
                    end
                    DONE: begin
                        go    <= 1'b1;
                        state <= IDLE;
                    end
`ifdef FRAME_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (accept) begin
                            go        <= (in_data == sum);
                            frame_err <= (in_data != sum);
                            state     <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader at 4x8 with a write scoreboard.
// Build with FRAME_LOADER_CHECKSUM_EN to also exercise the checksum path.
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        bank0_wen;
    logic        bank1_wen;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        go;
    logic        busy;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int go_cnt = 0;
    int mx = 0;
    int my = 0;
    int g0;
    logic [7:0]  msum = 8'h00;
    logic [21:0] exp_q[$];

    frame_loader #(.MATRIX_HEIGHT(4), .MATRIX_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .bank0_wen(bank0_wen),
        .bank1_wen(bank1_wen), .w_addr(w_addr), .w_data(w_data),
        .go(go), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the next expected pixel
    always @(negedge clk) begin
        if (go === 1'b1) go_cnt++;
        if (bank0_wen === 1'b1 || bank1_wen === 1'b1) begin
            if (exp_q.size() == 0)
                chk("unexpected_wen", {10'd0, bank0_wen, bank1_wen, w_addr, w_data}, 0);
            else
                chk("write", {10'd0, bank0_wen, bank1_wen, w_addr, w_data},
                    {10'd0, exp_q.pop_front()});
            chk("go_wen_excl", go, 0);
        end
    end

    task automatic send_byte(input logic s, input logic [7:0] d);
        int n = 0;
        while (in_ready !== 1'b1 && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", in_ready, 1);
        sof = s;
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof = 1'b0;
        if (s) msum = d;
        else msum = msum + d;
    endtask

    task automatic pixel(input logic s, input logic [15:0] d);
        if (s) begin
            mx = 0;
            my = 0;
        end
        send_byte(s, d[15:8]);
        exp_q.push_back({my < 2, my >= 2, 4'((my % 2) * 8 + mx), d});
        send_byte(1'b0, d[7:0]);
        mx++;
        if (mx == 8) begin
            mx = 0;
            my++;
        end
    endtask

    function automatic logic [15:0] pat(input int p);
        logic [15:0] v;
        v = 16'((p << 11) | (p << 5) | p);
        return v;
    endfunction

    task automatic finish_frame(input int g_before);
`ifdef FRAME_LOADER_CHECKSUM_EN
        send_byte(1'b0, msum);
        chk("go_pulse", go, 1);
        chk("frame_err_ok", frame_err, 0);
`else
        @(posedge clk);
        #1;
        chk("go_pulse", go, 1);
`endif
        chk("busy_after_go", busy, 0);
        @(posedge clk);
        #1;
        chk("go_one_cycle", go, 0);
        chk("go_count", go_cnt, g_before + 1);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wen", {bank0_wen, bank1_wen}, 0);
        chk("rst_addr", w_addr, 0);
        chk("rst_data", w_data, 0);
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", frame_err, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First pixel
        pixel(1'b1, 16'h0821);
        chk("p0_b0", bank0_wen, 1);
        chk("p0_b1", bank1_wen, 0);
        chk("p0_addr", w_addr, 0);
        chk("p0_data", w_data, 16'h0821);
        chk("p0_busy", busy, 1);

        // Full frame with bank split
        g0 = go_cnt;
        for (int p = 0; p < 32; p++) begin
            pixel(p == 0, pat(p));
            if (p == 17) begin
                chk("p17_b1", bank1_wen, 1);
                chk("p17_addr", w_addr, 1);
            end
        end
        chk("p31_b1", bank1_wen, 1);
        chk("p31_addr", w_addr, 15);
        chk("p31_data", w_data, pat(31));
        chk("p31_no_go", go, 0);
        finish_frame(g0);

        // Reset after a high byte
        send_byte(1'b1, 8'hAA);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", {bank0_wen, bank1_wen}, 0);
        chk("mid_rst_addr", w_addr, 0);
        chk("mid_rst_data", w_data, 0);
        chk("mid_rst_go", go, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bytes without sof are dropped
        g0 = go_cnt;
        send_byte(1'b0, 8'h55);
        send_byte(1'b0, 8'h66);
        send_byte(1'b0, 8'h77);
        chk("nosof_ready", in_ready, 1);
        chk("nosof_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("nosof_go", go_cnt, g0);
        for (int p = 0; p < 32; p++) pixel(p == 0, pat(31 - p));
        finish_frame(g0);

        // Abort after 5 pixels
        g0 = go_cnt;
        for (int p = 0; p < 5; p++) pixel(p == 0, 16'h1000 + 16'(p));
        pixel(1'b1, 16'hBEEF);
        chk("abort_b0", bank0_wen, 1);
        chk("abort_addr", w_addr, 0);
        for (int p = 1; p < 32; p++) pixel(1'b0, pat(p) ^ 16'h00F0);
        chk("abort_no_go", go_cnt, g0);
        finish_frame(g0);

`ifdef FRAME_LOADER_CHECKSUM_EN
        // Good checksum
        g0 = go_cnt;
        for (int p = 0; p < 32; p++) pixel(p == 0, 16'h0101);
        send_byte(1'b0, 8'h40);
        chk("cs_go", go, 1);
        chk("cs_err", frame_err, 0);
        @(posedge clk);
        #1;
        // Bad checksum
        g0 = go_cnt;
        for (int p = 0; p < 32; p++) pixel(p == 0, 16'h0101);
        send_byte(1'b0, 8'h41);
        chk("csbad_go", go, 0);
        chk("csbad_err", frame_err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("csbad_sticky", frame_err, 1);
        chk("csbad_gocnt", go_cnt, g0);
        send_byte(1'b1, 8'h12);
        chk("csbad_clear", frame_err, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("end_err", frame_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
